// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read, write and reservation signals of the scoreboarded register file.
interface reg_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic [ADDR_W-1:0] rd_addr_1;
    logic [ADDR_W-1:0] rd_addr_2;
    logic [DATA_W-1:0] rd_dat_1;
    logic [DATA_W-1:0] rd_dat_2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_dat;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              rsv_ok;
    logic              busy_1;
    logic              busy_2;

    modport master (
        output rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_dat, rsv_en, rsv_addr,
        input  rd_dat_1, rd_dat_2, rsv_ok, busy_1, busy_2
    );
    modport slave (
        input  rd_addr_1, rd_addr_2, wr_en, wr_addr, wr_dat, rsv_en, rsv_addr,
        output rd_dat_1, rd_dat_2, rsv_ok, busy_1, busy_2
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read/one-write register file with per-register busy bits for reservations.
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 2,
    parameter bit ZERO_REG = 0,
    parameter bit BYPASS   = 1
) (
    input logic        clk,
    input logic        reset,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;

    logic w_hit_1, w_hit_2, w_hit_r, w_zero_1, w_zero_2, w_zero_r, w_zero_w;

    assign w_hit_1  = bus.wr_en && bus.wr_addr == bus.rd_addr_1;
    assign w_hit_2  = bus.wr_en && bus.wr_addr == bus.rd_addr_2;
    assign w_hit_r  = bus.wr_en && bus.wr_addr == bus.rsv_addr;
    assign w_zero_1 = ZERO_REG && bus.rd_addr_1 == '0;
    assign w_zero_2 = ZERO_REG && bus.rd_addr_2 == '0;
    assign w_zero_r = ZERO_REG && bus.rsv_addr == '0;
    assign w_zero_w = ZERO_REG && bus.wr_addr == '0;

    assign bus.rd_dat_1 = w_zero_1 ? '0 : (BYPASS && w_hit_1) ? bus.wr_dat : r_mem[bus.rd_addr_1];
    assign bus.rd_dat_2 = w_zero_2 ? '0 : (BYPASS && w_hit_2) ? bus.wr_dat : r_mem[bus.rd_addr_2];
    assign bus.busy_1   = r_busy[bus.rd_addr_1] && !w_hit_1;
    assign bus.busy_2   = r_busy[bus.rd_addr_2] && !w_hit_2;
    assign bus.rsv_ok   = bus.rsv_en && (w_zero_r || !r_busy[bus.rsv_addr] || w_hit_r);

    // The reservation set is issued after the writeback clear so a same-edge reservation wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy <= '0;
        end else begin
            if (bus.wr_en && !w_zero_w) r_mem[bus.wr_addr] <= bus.wr_dat;
            if (bus.wr_en) r_busy[bus.wr_addr] <= 1'b0;
            if (bus.rsv_ok && !w_zero_r) r_busy[bus.rsv_addr] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench driving two configurations (plain/bypass and zero-reg/no-bypass).
module tb_reg_file_sb;
    typedef struct {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        b1;
        logic        b2;
        logic        ok;
    } exp_t;

    logic clk = 0;
    logic reset = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [15:0] m_mem [2][4];
    bit          m_busy [2][4];

    reg_file_sb_if #(.DATA_W(16), .ADDR_W(2)) bus0 ();
    reg_file_sb_if #(.DATA_W(16), .ADDR_W(2)) bus1 ();

    reg_file_sb #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave)
    );
    reg_file_sb #(.DATA_W(16), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) begin
            exp_t e;
            e = q0.pop_front();
            chk("cfg0 rd_dat_1", bus0.rd_dat_1, e.d1);
            chk("cfg0 rd_dat_2", bus0.rd_dat_2, e.d2);
            chk("cfg0 busy_1", {15'd0, bus0.busy_1}, {15'd0, e.b1});
            chk("cfg0 busy_2", {15'd0, bus0.busy_2}, {15'd0, e.b2});
            chk("cfg0 rsv_ok", {15'd0, bus0.rsv_ok}, {15'd0, e.ok});
        end
        if (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            chk("cfg1 rd_dat_1", bus1.rd_dat_1, e.d1);
            chk("cfg1 rd_dat_2", bus1.rd_dat_2, e.d2);
            chk("cfg1 busy_1", {15'd0, bus1.busy_1}, {15'd0, e.b1});
            chk("cfg1 busy_2", {15'd0, bus1.busy_2}, {15'd0, e.b2});
            chk("cfg1 rsv_ok", {15'd0, bus1.rsv_ok}, {15'd0, e.ok});
        end
    end

    // Reference: config 0 has no zero register and forwards writes; config 1 is the opposite.
    function automatic exp_t predict(input int k, input bit we, input logic [1:0] wa,
                                     input logic [15:0] wd, input bit re, input logic [1:0] ra,
                                     input logic [1:0] a1, input logic [1:0] a2);
        exp_t e;
        bit zr = (k == 1);
        bit bp = (k == 0);
        e.d1 = (zr && a1 == 0) ? 16'h0 : (bp && we && wa == a1) ? wd : m_mem[k][a1];
        e.d2 = (zr && a2 == 0) ? 16'h0 : (bp && we && wa == a2) ? wd : m_mem[k][a2];
        e.b1 = m_busy[k][a1] && !(we && wa == a1);
        e.b2 = m_busy[k][a2] && !(we && wa == a2);
        e.ok = re && ((zr && ra == 0) || !m_busy[k][ra] || (we && wa == ra));
        return e;
    endfunction

    function automatic void advance(input int k, input bit rs, input bit we, input logic [1:0] wa,
                                    input logic [15:0] wd, input bit ok, input logic [1:0] ra);
        bit zr = (k == 1);
        for (int a = 0; a < 4; a++) begin
            if (rs) begin
                m_mem[k][a]  = 16'h0;
                m_busy[k][a] = 0;
            end else begin
                if (we && wa == a && !(zr && a == 0)) m_mem[k][a] = wd;
                if (ok && ra == a && !(zr && a == 0)) m_busy[k][a] = 1;
                else if (we && wa == a) m_busy[k][a] = 0;
            end
        end
    endfunction

    task automatic step(input bit rs, input bit we, input logic [1:0] wa, input logic [15:0] wd,
                        input bit re, input logic [1:0] ra, input logic [1:0] a1, input logic [1:0] a2);
        exp_t e0, e1;
        reset = rs;
        bus0.wr_en = we; bus0.wr_addr = wa; bus0.wr_dat = wd;
        bus0.rsv_en = re; bus0.rsv_addr = ra; bus0.rd_addr_1 = a1; bus0.rd_addr_2 = a2;
        bus1.wr_en = we; bus1.wr_addr = wa; bus1.wr_dat = wd;
        bus1.rsv_en = re; bus1.rsv_addr = ra; bus1.rd_addr_1 = a1; bus1.rd_addr_2 = a2;
        e0 = predict(0, we, wa, wd, re, ra, a1, a2);
        e1 = predict(1, we, wa, wd, re, ra, a1, a2);
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        advance(0, rs, we, wa, wd, e0.ok, ra);
        advance(1, rs, we, wa, wd, e1.ok, ra);
        #1;
    endtask

    initial begin
        reset = 1;
        bus0.wr_en = 0; bus0.wr_addr = 0; bus0.wr_dat = 0;
        bus0.rsv_en = 0; bus0.rsv_addr = 0; bus0.rd_addr_1 = 0; bus0.rd_addr_2 = 0;
        bus1.wr_en = 0; bus1.wr_addr = 0; bus1.wr_dat = 0;
        bus1.rsv_en = 0; bus1.rsv_addr = 0; bus1.rd_addr_1 = 0; bus1.rd_addr_2 = 0;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 4; a++) begin
                m_mem[k][a] = 16'h0;
                m_busy[k][a] = 0;
            end
        @(posedge clk);
        #1;
        // reset state with concurrent write and reservation that must not take effect
        step(1, 1, 2, 16'h7777, 1, 1, 2, 1);
        step(0, 0, 0, 16'h0,    0, 0, 2, 1);
        // write then read back
        step(0, 1, 2, 16'hA5A5, 0, 0, 0, 0);
        step(0, 0, 0, 16'h0,    0, 0, 2, 2);
        // same-cycle forwarding on both ports
        step(0, 1, 1, 16'h0001, 0, 0, 0, 0);
        step(0, 1, 1, 16'hBEEF, 0, 0, 1, 1);
        step(0, 0, 0, 16'h0,    0, 0, 1, 1);
        // reserve, rejected retry, writeback clears busy
        step(0, 0, 0, 16'h0,    1, 3, 3, 3);
        step(0, 0, 0, 16'h0,    1, 3, 3, 3);
        step(0, 1, 3, 16'h1234, 0, 0, 3, 3);
        step(0, 0, 0, 16'h0,    0, 0, 3, 3);
        // writeback and re-reservation on the same edge
        step(0, 0, 0, 16'h0,    1, 3, 3, 2);
        step(0, 1, 3, 16'h0F0F, 1, 3, 3, 3);
        step(0, 0, 0, 16'h0,    1, 3, 3, 3);
        // register 0
        step(0, 1, 0, 16'hFFFF, 1, 0, 0, 0);
        step(0, 0, 0, 16'h0,    1, 0, 0, 0);
        step(0, 0, 0, 16'h0,    0, 0, 0, 3);
        // reset drops pending reservation and pending write
        step(0, 0, 0, 16'h0,    1, 1, 1, 2);
        step(0, 1, 2, 16'h5555, 0, 0, 1, 2);
        step(1, 1, 2, 16'h7777, 1, 0, 1, 2);
        step(0, 0, 0, 16'h0,    0, 0, 1, 2);
        step(0, 0, 0, 16'h0,    1, 1, 0, 3);
        step(0, 1, 1, 16'hCAFE, 0, 0, 1, 0);
        step(0, 0, 0, 16'h0,    0, 0, 1, 1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, 1'($urandom), 2'($urandom), 16'($urandom),
                 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard drain got=%0d/%0d expected=0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 16, data width of every register and data port.
REQ-002 Parameter ADDR_W, default 2, address width; depth SHALL be 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0, 1 = register 0 hardwired to zero.
REQ-004 Parameter BYPASS, default 1, 1 = same-cycle write data forwarded to read ports.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 rd_addr_1  input  ADDR_W  read port 1 address.
REQ-008 rd_addr_2  input  ADDR_W  read port 2 address.
REQ-009 rd_dat_1  output  DATA_W  read port 1 data.
REQ-010 rd_dat_2  output  DATA_W  read port 2 data.
REQ-011 wr_en  input  1  write strobe; also writeback that clears the busy bit.
REQ-012 wr_addr  input  ADDR_W  write address.
REQ-013 wr_dat  input  DATA_W  write data.
REQ-014 rsv_en  input  1  reservation request: mark rsv_addr busy.
REQ-015 rsv_addr  input  ADDR_W  reservation address.
REQ-016 rsv_ok  output  1  reservation at rsv_addr is accepted this cycle.
REQ-017 busy_1  output  1  register at rd_addr_1 is pending a writeback.
REQ-018 busy_2  output  1  register at rd_addr_2 is pending a writeback.

Function
REQ-019 Storage and busy bits SHALL update only on rising clk; all outputs SHALL be combinational from state and current inputs.
REQ-020 wr_en=1 SHALL write wr_dat to register wr_addr at the edge; full DATA_W, no truncation or extension.
REQ-021 rd_dat_n SHALL equal register[rd_addr_n], except as REQ-022/REQ-023 state.
REQ-022 BYPASS=1: wr_en=1 and wr_addr==rd_addr_n SHALL drive rd_dat_n=wr_dat in the same cycle; BYPASS=0: old value until the edge.
REQ-023 ZERO_REG=1: reads of address 0 SHALL return 0, writes to 0 SHALL be ignored, busy for 0 SHALL always be 0.
REQ-024 Busy bit per register; busy_n = busy[rd_addr_n] AND NOT (wr_en AND wr_addr==rd_addr_n), i.e. a writeback in progress clears visible busy in the same cycle.
REQ-025 rsv_ok = rsv_en AND (NOT busy[rsv_addr] OR (wr_en AND wr_addr==rsv_addr)); forced 1 for address 0 when ZERO_REG=1 and rsv_en=1.
REQ-026 rsv_ok=1 SHALL set busy[rsv_addr] at the edge (except address 0 with ZERO_REG=1).
REQ-027 rsv_en=1 with rsv_ok=0 SHALL leave all state unchanged; the requester retries.
REQ-028 wr_en=1 SHALL clear busy[wr_addr] at the edge unless the same edge sets it by REQ-026 (set wins).
REQ-029 Write to a non-busy register SHALL be accepted normally (no error, busy stays 0).
REQ-030 Simultaneous reservations on distinct addresses are impossible (single port); read ports are independent and may alias each other or wr_addr.

Reset
REQ-031 reset=1 at a rising edge SHALL clear every register to 0 and every busy bit to 0.
REQ-032 reset SHALL override wr_en and rsv_en on the same edge; neither write nor reservation takes effect.
REQ-033 During reset cycles outputs SHALL follow REQ-021..REQ-025 from current state and inputs; after first reset edge all rd_dat=0, busy_n=0.
REQ-034 Reset asserted mid-reservation SHALL drop all pending reservations; later writebacks are treated as plain writes.

Verification (DATA_W=16, ADDR_W=2)
REQ-035 Reset, then write 0xA5A5 to r2, next cycle rd_addr_1=2 -> rd_dat_1=0xA5A5, busy_1=0.
REQ-036 BYPASS=1: r1=0x0001, same cycle wr_en r1=0xBEEF and rd_addr_1=rd_addr_2=1 -> both rd_dat=0xBEEF before edge; BYPASS=0 -> 0x0001 until edge.
REQ-037 rsv_en r3 -> rsv_ok=1, next cycle busy for r3=1; rsv_en r3 again -> rsv_ok=0, state unchanged; wr_en r3=0x1234 -> busy for r3=0 same cycle, rd_dat=0x1234 (BYPASS=1).
REQ-038 r3 busy, same cycle wr_en r3=0x0F0F and rsv_en r3 -> rsv_ok=1, after edge r3=0x0F0F and busy for r3=1.
REQ-039 ZERO_REG=1: wr_en r0=0xFFFF, rsv_en r0 -> rsv_ok=1, rd_dat for r0=0, busy=0 at all times.
REQ-040 r1 busy, r2=0x5555, reset with wr_en r2=0x7777 and rsv_en r0 -> after edge all registers 0, all busy 0.
